stall_reg_file: RTL and testbench
=================================

STALL_REG_FILE -- requirements
Module: stall_reg_file

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 10, number of words.
REQ-003 SHALL provide parameter ADDR_W, default 4, address width; ADDR_W >= clog2(DEPTH).
REQ-004 SHALL provide parameter NRD, default 2, number of read ports.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL provide port clk, input, 1, rising-edge clock.
REQ-007 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL provide port stall, input, 1, freezes read outputs and blocks writes.
REQ-009 SHALL provide port we, input, 1, write enable.
REQ-010 SHALL provide port waddr, input, ADDR_W, write address.
REQ-011 SHALL provide port wdata, input, DATA_W, write data.
REQ-012 SHALL provide port rd_en, input, NRD, per-port read request.
REQ-013 SHALL provide port raddr, input, NRD*ADDR_W, packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-014 SHALL provide port rdata, output, NRD*DATA_W, packed registered read data.
REQ-015 SHALL provide port rd_valid, output, NRD, rdata slice valid.
REQ-016 SHALL provide port err_clr, input, 1, clears the sticky error flag.
REQ-017 SHALL provide port oor_err, output, 1, sticky out-of-range access flag.

Function
REQ-018 SHALL perform reads with 1-cycle latency: rd_en[i]=1 at edge N gives rdata slice i and rd_valid[i]=1 after edge N.
REQ-019 SHALL drive rd_valid[i]=0 after an edge where rd_en[i]=0 and stall=0; the rdata slice holds its previous value.
REQ-020 SHALL, while stall=1, hold rdata and rd_valid unchanged and ignore rd_en, we and err_clr.
REQ-021 SHALL write wdata to waddr at the edge when we=1, stall=0 and waddr<DEPTH.
REQ-022 SHALL, for an address >= DEPTH, ignore the write and return all-zero read data with rd_valid=1.
REQ-023 SHALL set oor_err at the edge following any unstalled out-of-range read or write; oor_err stays 1 until err_clr or rst.
REQ-024 SHALL give set priority when err_clr and a new out-of-range access occur in the same cycle: oor_err stays 1.
REQ-025 SHALL let several read ports read the same address in one cycle; every one of them returns identical data.
REQ-026 SHALL, when a read and a write hit the same address in one cycle, follow REQ-034 (BYPASS_EN behaviour).
REQ-027 SHALL, when stall is deasserted, sample new inputs at the first edge where stall=0.

Reset
REQ-028 SHALL clear all DEPTH words to 0 at a clock edge while rst=1.
REQ-029 SHALL clear rdata to 0, rd_valid to 0 and oor_err to 0 while rst=1.
REQ-030 SHALL give rst priority over stall, we and rd_en; a write in a reset cycle is discarded.
REQ-031 SHALL, when rst asserts mid-stall, leave stall=0 behaviour in effect after reset; the frozen outputs are lost.

Configuration
REQ-032 SHALL support macro STALL_REG_FILE_BYPASS_EN.
REQ-033 SHALL, with the macro undefined, return the pre-write (old) word on a same-cycle read/write address match.
REQ-034 SHALL, with the macro defined, return wdata on that read port on a same-cycle in-range read/write address match with we=1 and stall=0.

Structure
REQ-035 SHALL place default DATA_W/DEPTH/ADDR_W/NRD constants and a word typedef in package stall_reg_file_pkg.
REQ-036 SHALL implement each read port as one instance of sub-module srf_read_port; it holds the output register, valid bit, stall hold and bypass mux.
REQ-037 SHALL use a generate loop over NRD to instantiate the read ports; the storage array stays in the top module.

Verification
REQ-038 SHALL test: rst, then read addr 3 on port 0 -> rdata[31:0]=0, rd_valid[0]=1 one cycle later.
REQ-039 SHALL test: write 0xDEADBEEF to addr 5, next cycle read addr 5 on both ports -> both slices = 0xDEADBEEF.
REQ-040 SHALL test: same-cycle write 0x1234 to addr 2 and read addr 2 (addr 2 previously 0x55) -> 0x1234 with BYPASS_EN, 0x55 without.
REQ-041 SHALL test: stall=1 for 3 cycles with we=1 to addr 1 and varying raddr -> rdata/rd_valid frozen, addr 1 unchanged afterward.
REQ-042 SHALL test: read addr 12 (DEPTH=10) -> rdata=0, rd_valid=1, oor_err=1; err_clr -> oor_err=0; err_clr together with a write to addr 15 -> oor_err stays 1.
REQ-043 SHALL test: rst asserted during stall after writes -> all words read back 0 and all outputs cleared.

Source files
------------

// File: rtl/stall_reg_file_pkg.sv
// Shared defaults for the stalling register file.
// Contents:
//   DefDataW / DefDepth / DefAddrW / DefNrd - default geometry
//   word_t                                  - one storage word at the default width
package stall_reg_file_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefDepth = 10;
  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefNrd   = 2;

  typedef logic [DefDataW-1:0] word_t;

endpackage

// File: rtl/srf_read_port.sv
// One registered read port of the stalling register file.
// Optional feature: define STALL_REG_FILE_BYPASS_EN to forward same-cycle write data.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   stall_i        - hold output register and valid bit
//   rd_en_i        - read request for this port
//   in_range_i     - requested address is below DEPTH
//   mem_word_i     - stored word at the requested address (pre-write)
//   wr_hit_i       - in-range unstalled write to the same address this cycle
//   wdata_i        - write data, used for forwarding
//   rdata_o        - registered read data
//   rd_valid_o     - rdata_o holds a result from the last unstalled edge
module srf_read_port
  import stall_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              rd_en_i,
  input  logic              in_range_i,
  input  logic [DATA_W-1:0] mem_word_i,
  input  logic              wr_hit_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rd_valid_o
);

  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] sel_word;

`ifdef STALL_REG_FILE_BYPASS_EN
  assign sel_word = wr_hit_i ? wdata_i : mem_word_i;
`else
  // Old word is returned on a read/write collision; forwarding inputs are unused.
  logic unused_bypass;
  assign unused_bypass = ^{wr_hit_i, wdata_i};
  assign sel_word      = mem_word_i;
`endif

  always_comb begin
    rdata_d = rdata_q;
    valid_d = valid_q;
    if (!stall_i) begin
      valid_d = rd_en_i;
      // Data only updates on a request; an idle port keeps its last word.
      if (rd_en_i) begin
        rdata_d = in_range_i ? sel_word : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign rd_valid_o = valid_q;

endmodule

// File: rtl/stall_reg_file.sv
// Multi-read-port register file with a global stall and a sticky out-of-range flag.
// Optional feature: define STALL_REG_FILE_BYPASS_EN to return wdata on a same-cycle
// read/write address match (otherwise the old word is returned).
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset; clears storage, outputs and flag
//   stall    - freezes read outputs, blocks writes, ignores err_clr
//   we/waddr/wdata - write port
//   rd_en    - per-port read request
//   raddr    - packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata    - packed registered read data, port i at [i*DATA_W +: DATA_W]
//   rd_valid - per-port valid
//   err_clr  - clears oor_err (a same-cycle out-of-range access wins)
//   oor_err  - sticky out-of-range access flag
module stall_reg_file
  import stall_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NRD    = DefNrd
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [NRD-1:0]         rd_en,
  input  logic [NRD*ADDR_W-1:0]  raddr,
  output logic [NRD*DATA_W-1:0]  rdata,
  output logic [NRD-1:0]         rd_valid,
  input  logic                   err_clr,
  output logic                   oor_err
);

  localparam int unsigned     IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DepthA = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_in_range;
  logic              wr_en;
  logic [NRD-1:0]    rd_in_range;
  logic [NRD-1:0]    wr_hit;
  logic [DATA_W-1:0] rd_word [NRD];
  logic              oor_hit;
  logic              oor_d, oor_q;

  assign wr_in_range = ({1'b0, waddr} < DepthA);
  assign wr_en       = we && !stall && wr_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr[IdxW-1:0]] <= wdata;
    end
  end

  for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra             = raddr[g*ADDR_W +: ADDR_W];
    assign rd_in_range[g] = ({1'b0, ra} < DepthA);
    assign rd_word[g]     = rd_in_range[g] ? mem_q[ra[IdxW-1:0]] : '0;
    assign wr_hit[g]      = wr_en && (waddr == ra);

    srf_read_port #(
      .DATA_W (DATA_W)
    ) u_port (
      .clk_i      (clk),
      .rst_i      (rst),
      .stall_i    (stall),
      .rd_en_i    (rd_en[g]),
      .in_range_i (rd_in_range[g]),
      .mem_word_i (rd_word[g]),
      .wr_hit_i   (wr_hit[g]),
      .wdata_i    (wdata),
      .rdata_o    (rdata[g*DATA_W +: DATA_W]),
      .rd_valid_o (rd_valid[g])
    );
  end

  always_comb begin
    oor_hit = we && !wr_in_range;
    for (int i = 0; i < int'(NRD); i++) begin
      oor_hit = oor_hit | (rd_en[i] & ~rd_in_range[i]);
    end
  end

  // A new violation takes priority over a same-cycle clear.
  always_comb begin
    oor_d = oor_q;
    if (!stall) begin
      if (oor_hit) begin
        oor_d = 1'b1;
      end else if (err_clr) begin
        oor_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oor_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
    end
  end

  assign oor_err = oor_q;

endmodule

// File: tb/tb_stall_reg_file.sv
module tb_stall_reg_file;
  import stall_reg_file_pkg::*;

  localparam int DW = 32;
  localparam int DEP = 10;
  localparam int AW = 4;
  localparam int NR = 2;

`ifdef STALL_REG_FILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, stall, we, err_clr;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rd_valid;
  logic             oor_err;

  stall_reg_file #(
    .DATA_W (DW),
    .DEPTH  (DEP),
    .ADDR_W (AW),
    .NRD    (NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rd_en    (rd_en),
    .raddr    (raddr),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .err_clr  (err_clr),
    .oor_err  (oor_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  word_t       m_mem [DEP];
  word_t       m_rdata [NR];
  bit [NR-1:0] m_valid;
  bit          m_oor;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply the expected effect of one clock edge given the current inputs.
  task automatic model_edge();
    bit viol;
    int a;
    int wa;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      foreach (m_rdata[i]) m_rdata[i] = '0;
      m_valid = '0;
      m_oor   = 1'b0;
      return;
    end
    if (stall) return;
    viol = 1'b0;
    wa   = int'(waddr);
    for (int p = 0; p < NR; p++) begin
      a = int'(raddr[p*AW +: AW]);
      m_valid[p] = rd_en[p];
      if (rd_en[p]) begin
        if (a >= DEP) begin
          m_rdata[p] = '0;
          viol = 1'b1;
        end else if (Bypass && we && wa == a) begin
          m_rdata[p] = wdata;
        end else begin
          m_rdata[p] = m_mem[a];
        end
      end
    end
    if (we) begin
      if (wa < DEP) m_mem[wa] = wdata;
      else viol = 1'b1;
    end
    if (viol) m_oor = 1'b1;
    else if (err_clr) m_oor = 1'b0;
  endtask

  task automatic cyc(input bit r, input bit s, input bit w, input int wa, input logic [DW-1:0] wd,
                     input bit [NR-1:0] re, input int ra0, input int ra1, input bit ec);
    rst   = r;
    stall = s;
    we    = w;
    waddr = AW'(wa);
    wdata = wd;
    rd_en = re;
    raddr = {AW'(ra1), AW'(ra0)};
    err_clr = ec;
    model_edge();
    @(posedge clk);
    #1;
    check("rdata", 64'(rdata), {m_rdata[1], m_rdata[0]});
    check("rd_valid", 64'(rd_valid), 64'(m_valid));
    check("oor_err", 64'(oor_err), 64'(m_oor));
  endtask

  initial begin
    logic [DW-1:0] frz_data;
    logic [NR-1:0] frz_valid;
    logic [DW-1:0] exp40;
    foreach (m_mem[i]) m_mem[i] = '0;
    foreach (m_rdata[i]) m_rdata[i] = '0;
    m_valid = '0;
    m_oor   = 1'b0;
    rst = 1'b1; stall = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    rd_en = '0; raddr = '0; err_clr = 1'b0;

    // Reset
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_valid", 64'(rd_valid), 64'd0);
    check("reset_oor", 64'(oor_err), 64'd0);

    // Read after reset
    cyc(0, 0, 0, 0, 0, 2'b01, 3, 0, 0);
    check("rd3_data", 64'(rdata[31:0]), 64'd0);
    check("rd3_valid", 64'(rd_valid[0]), 64'd1);

    // Write then dual read of the same address
    cyc(0, 0, 1, 5, 32'hDEADBEEF, 2'b00, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b11, 5, 5, 0);
    check("dual_p0", 64'(rdata[31:0]), 64'hDEADBEEF);
    check("dual_p1", 64'(rdata[63:32]), 64'hDEADBEEF);

    // Same-cycle read/write collision
    cyc(0, 0, 1, 2, 32'h55, 2'b00, 0, 0, 0);
    cyc(0, 0, 1, 2, 32'h1234, 2'b01, 2, 0, 0);
    exp40 = Bypass ? 32'h1234 : 32'h55;
    check("collide", 64'(rdata[31:0]), 64'(exp40));

    // Stall freezes outputs and blocks writes
    cyc(0, 0, 0, 0, 0, 2'b11, 5, 2, 0);
    frz_data  = rdata[31:0];
    frz_valid = rd_valid;
    check("pre_stall", 64'(frz_data), 64'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 1, 32'hAAAA_0000 + k, 2'b11, k, 9 - k, 0);
      check("stall_p0", 64'(rdata[31:0]), 64'hDEADBEEF);
      check("stall_p1", 64'(rdata[63:32]), 64'h1234);
      check("stall_valid", 64'(rd_valid), 64'(frz_valid));
    end
    cyc(0, 0, 0, 0, 0, 2'b01, 1, 0, 0);
    check("addr1_kept", 64'(rdata[31:0]), 64'd0);
    check("idle_valid1", 64'(rd_valid[1]), 64'd0);

    // Out-of-range access and sticky flag
    cyc(0, 0, 0, 0, 0, 2'b01, 12, 0, 0);
    check("oor_data", 64'(rdata[31:0]), 64'd0);
    check("oor_valid", 64'(rd_valid[0]), 64'd1);
    check("oor_set", 64'(oor_err), 64'd1);
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    check("oor_clr", 64'(oor_err), 64'd0);
    cyc(0, 0, 1, 15, 32'hFFFF, 2'b00, 0, 0, 1);
    check("oor_set_wins", 64'(oor_err), 64'd1);

    // Reset during stall
    cyc(0, 0, 1, 0, 32'h1111, 2'b00, 0, 0, 0);
    cyc(0, 0, 1, 9, 32'h9999, 2'b11, 0, 12, 0);
    cyc(0, 1, 1, 4, 32'h4444, 2'b11, 1, 1, 0);
    cyc(1, 1, 1, 4, 32'h4444, 2'b11, 9, 9, 0);
    check("rst_stall_data", 64'(rdata), 64'd0);
    check("rst_stall_valid", 64'(rd_valid), 64'd0);
    check("rst_stall_oor", 64'(oor_err), 64'd0);
    for (int a = 0; a < DEP; a += 2) begin
      cyc(0, 0, 0, 0, 0, 2'b11, a, a + 1, 0);
      check("cleared", 64'(rdata), 64'd0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
          $urandom_range(0, 15), $urandom, NR'($urandom), $urandom_range(0, 15),
          $urandom_range(0, 15), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
